count_zero_iter: RTL

COUNT_ZERO_ITER -- requirements
Module: count_zero_iter

---
 rtl/count_zero_iter_pkg.sv | 10 +
 rtl/count_zero_iter_if.sv | 26 ++
 rtl/count_zero_iter_seg_lzc.sv | 19 +
 rtl/count_zero_iter.sv | 88 ++++++++
 4 files changed

// File: rtl/count_zero_iter_pkg.sv
// Shared types for the iterative leading/trailing zero counter.
package count_zero_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   function automatic int cnt_w(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/count_zero_iter_if.sv
// Request/response handshake bundle for count_zero_iter.
interface count_zero_iter_if
   import count_zero_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = cnt_w(DATA_W)
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  out_count;
   logic              out_zero;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_count, out_zero
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_count, out_zero
   );
endinterface

// File: rtl/count_zero_iter_seg_lzc.sv
// Combinational leading-zero count of one SEG_W-bit segment.
module seg_lzc #(
   parameter int SEG_W = 4
) (
   input  logic [SEG_W-1:0]           seg,
   output logic [$clog2(SEG_W+1)-1:0] lz,
   output logic                       all_zero
);
   localparam int LZ_W = $clog2(SEG_W + 1);

   // Walk LSB to MSB so the most significant set bit has the final say.
   always_comb begin
      lz = LZ_W'(SEG_W);
      for (int i = 0; i < SEG_W; i++)
         if (seg[i]) lz = LZ_W'(SEG_W - 1 - i);
   end

   assign all_zero = ~|seg;
endmodule

// File: rtl/count_zero_iter.sv
// Iterative leading/trailing zero counter: scans SEG_W bits per cycle, MSB first.
module count_zero_iter
   import count_zero_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int SEG_W  = 4
) (
   input logic              clk,
   input logic              rst,
   count_zero_iter_if.slave bus
);
   localparam int CNT_W = cnt_w(DATA_W);
   localparam int NSEG  = DATA_W / SEG_W;
   localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int LZ_W  = $clog2(SEG_W + 1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] word, in_rev;
   logic [CNT_W-1:0]  count, out_count_q;
   logic [IDX_W-1:0]  idx;
   logic              out_zero_q;
   logic [LZ_W-1:0]   seg_lz;
   logic              seg_zero, last_seg, accept;

   always_comb begin
      in_rev = '0;
      for (int i = 0; i < DATA_W; i++) in_rev[i] = bus.in_data[DATA_W-1-i];
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state == DONE);
   assign bus.out_count = out_count_q;
   assign bus.out_zero  = out_zero_q;
   assign last_seg      = (idx == IDX_W'(NSEG - 1));

   // The captured word shifts left each scan cycle, so the segment under
   // examination is always the top SEG_W bits.
   seg_lzc #(.SEG_W(SEG_W)) u_seg_lzc (
      .seg      (word[DATA_W-1 -: SEG_W]),
      .lz       (seg_lz),
      .all_zero (seg_zero)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SCAN;
         SCAN:    if (!seg_zero || last_seg) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         word        <= '0;
         count       <= '0;
         idx         <= '0;
         out_count_q <= '0;
         out_zero_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (accept) begin
               word  <= bus.in_mode ? in_rev : bus.in_data;
               count <= '0;
               idx   <= '0;
            end
            SCAN: begin
               if (seg_zero && !last_seg) begin
                  count <= count + CNT_W'(SEG_W);
                  idx   <= idx + IDX_W'(1);
                  word  <= word << SEG_W;
               end else if (seg_zero) begin
                  out_count_q <= CNT_W'(DATA_W);
                  out_zero_q  <= 1'b1;
               end else begin
                  out_count_q <= count + CNT_W'(seg_lz);
                  out_zero_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
